// File: rtl/nw_pkg.sv
// Shared types and helpers for the Needleman-Wunsch wavefront sequencer.
package nw_pkg;

  localparam int SCORE_W = 32;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CLEAR  = 3'd1,
    INIT   = 3'd2,
    WAVE   = 3'd3,
    FINISH = 3'd4
  } wf_state_t;

  // Anti-diagonal index of cell (i,j); cells on one diagonal are independent.
  function automatic int diag_of(input int i, input int j);
    return i + j;
  endfunction

endpackage

// File: rtl/nw_boundary_gen.sv
// Builds the row-0 / column-0 boundary scores k*GAP, one k per enabled cycle.
module nw_boundary_gen
  import nw_pkg::*;
#(
  parameter int                        N   = 29,
  parameter int                        M   = 29,
  parameter logic signed [SCORE_W-1:0] GAP = -32'sd1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          i_clear,
  input  logic                          i_en,
  output logic [M:0][SCORE_W-1:0]       o_top,
  output logic [N:0][SCORE_W-1:0]       o_left,
  output logic                          o_last
);

  localparam int KMAX = (N > M) ? N : M;
  localparam int KW   = $clog2(KMAX + 1) + 1;
  localparam logic [KW-1:0] K_ONE = KW'(1);

  logic [KW-1:0]               r_k;
  logic signed [SCORE_W-1:0]   r_acc;
  logic [M:0][SCORE_W-1:0]     r_top;
  logic [N:0][SCORE_W-1:0]     r_left;

  // k counter and running k*GAP accumulator (wraps in two's complement).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_k   <= '0;
      r_acc <= '0;
    end else if (i_clear) begin
      r_k   <= '0;
      r_acc <= '0;
    end else if (i_en) begin
      r_k   <= r_k + K_ONE;
      r_acc <= r_acc + GAP;
    end else begin
      r_k   <= r_k;
      r_acc <= r_acc;
    end
  end

  // Boundary registers: slot k takes the accumulator on the cycle k is current.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_top  <= '0;
      r_left <= '0;
    end else if (i_clear) begin
      r_top  <= '0;
      r_left <= '0;
    end else if (i_en) begin
      for (int j = 0; j <= M; j++) begin
        if (int'(r_k) == j) r_top[j] <= r_acc;
      end
      for (int i = 0; i <= N; i++) begin
        if (int'(r_k) == i) r_left[i] <= r_acc;
      end
    end else begin
      r_top  <= r_top;
      r_left <= r_left;
    end
  end

  assign o_top  = r_top;
  assign o_left = r_left;
  assign o_last = (int'(r_k) == KMAX);

endmodule

// File: rtl/nw_wavefront_ctrl.sv
// Wavefront sequencer: clears the cell grid, builds boundaries, fires
// anti-diagonals in order and captures the bottom-right score.
module nw_wavefront_ctrl
  import nw_pkg::*;
#(
  parameter int                        N   = 29,
  parameter int                        M   = 29,
  parameter logic signed [SCORE_W-1:0] GAP = -32'sd1
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            go,
  input  logic [N*M-1:0]                  pu_done,
  input  logic signed [SCORE_W-1:0]       final_score,
  output logic                            pu_reset,
  output logic [N*M-1:0]                  pu_start,
  output logic [(M+1)*SCORE_W-1:0]        bound_top,
  output logic [(N+1)*SCORE_W-1:0]        bound_left,
  output logic                            busy,
  output logic                            done,
  output logic signed [SCORE_W-1:0]       score
);

  localparam int LAST_D = N + M - 2;
  localparam int DW     = $clog2(N + M) + 1;
  localparam logic [DW-1:0] D_ONE = DW'(1);

  wf_state_t                  r_state;
  wf_state_t                  w_next;
  logic [DW-1:0]              r_d;
  logic                       w_diag_done;
  logic                       w_bnd_clear;
  logic                       w_bnd_en;
  logic                       w_last;
  logic [N*M-1:0]             w_start;
  logic [M:0][SCORE_W-1:0]    w_top;
  logic [N:0][SCORE_W-1:0]    w_left;
  logic                       r_busy;
  logic                       r_done;
  logic signed [SCORE_W-1:0]  r_score;

  nw_boundary_gen #(
    .N   (N),
    .M   (M),
    .GAP (GAP)
  ) u_bnd (
    .clk     (clk),
    .reset   (reset),
    .i_clear (w_bnd_clear),
    .i_en    (w_bnd_en),
    .o_top   (w_top),
    .o_left  (w_left),
    .o_last  (w_last)
  );

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic and boundary-generator controls.
  always_comb begin
    w_next      = r_state;
    w_bnd_clear = 1'b0;
    w_bnd_en    = 1'b0;
    case (r_state)
      IDLE: begin
        if (go) w_next = CLEAR;
        else    w_next = IDLE;
      end
      CLEAR: begin
        w_bnd_clear = 1'b1;
        w_next      = INIT;
      end
      INIT: begin
        w_bnd_en = 1'b1;
        if (w_last) w_next = WAVE;
        else        w_next = INIT;
      end
      WAVE: begin
        if (w_diag_done && (int'(r_d) == LAST_D)) w_next = FINISH;
        else                                      w_next = WAVE;
      end
      FINISH: begin
        w_next = IDLE;
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  // Current diagonal: cleared on leaving INIT, advanced once its cells report done.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_d <= '0;
    end else if ((r_state == INIT) && w_last) begin
      r_d <= '0;
    end else if ((r_state == WAVE) && w_diag_done && (int'(r_d) < LAST_D)) begin
      r_d <= r_d + D_ONE;
    end else begin
      r_d <= r_d;
    end
  end

  // Start mask: every cell on or before the current diagonal; inputs of earlier ones are stable.
  always_comb begin
    w_start = '0;
    if (r_state == WAVE) begin
      for (int i = 0; i < N; i++) begin
        for (int j = 0; j < M; j++) begin
          w_start[i*M+j] = (diag_of(i, j) <= int'(r_d));
        end
      end
    end else begin
      w_start = '0;
    end
  end

  // Diagonal completion: all cells on diagonal d done; cells on later diagonals ignored.
  always_comb begin
    w_diag_done = 1'b1;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < M; j++) begin
        w_diag_done = w_diag_done & (pu_done[i*M+j] | (diag_of(i, j) != int'(r_d)));
      end
    end
  end

  // Host handshake outputs; score is captured as FINISH is entered so it is valid with done.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_score <= '0;
    end else begin
      r_busy <= (w_next != IDLE);
      r_done <= (w_next == FINISH);
      if (w_next == FINISH) r_score <= final_score;
      else                  r_score <= r_score;
    end
  end

  assign pu_reset   = (r_state == CLEAR) | ~reset;
  assign pu_start   = w_start;
  assign bound_top  = w_top;
  assign bound_left = w_left;
  assign busy       = r_busy;
  assign done       = r_done;
  assign score      = r_score;

endmodule

// File: tb/tb_nw_wavefront_ctrl.sv
// Directed bench for nw_wavefront_ctrl: 3x3 grid with a behavioural cell model,
// plus a 1x1 instance for the single-diagonal case.
module tb_nw_wavefront_ctrl;

  logic clk;
  logic reset;

  // 3x3 instance
  logic               go3;
  logic [8:0]         pu_done3;
  logic signed [31:0] final_score3;
  logic               pu_reset3;
  logic [8:0]         pu_start3;
  logic [127:0]       bound_top3;
  logic [127:0]       bound_left3;
  logic               busy3;
  logic               done3;
  logic signed [31:0] score3;

  // 1x1 instance
  logic               go1;
  logic [0:0]         pu_done1;
  logic signed [31:0] final_score1;
  logic               pu_reset1;
  logic [0:0]         pu_start1;
  logic [63:0]        bound_top1;
  logic [63:0]        bound_left1;
  logic               busy1;
  logic               done1;
  logic signed [31:0] score1;

  int n_checks = 0;
  int n_pass   = 0;

  // cell model state
  logic [8:0]         done_m;
  int                 h_m [9];
  logic [8:0]         hold_mask;
  logic               use_model;
  logic signed [31:0] fixed_score;
  logic [7:0]         seq_a [3];
  logic [7:0]         seq_b [3];

  nw_wavefront_ctrl #(.N(3), .M(3), .GAP(-32'sd1)) dut3 (
    .clk(clk), .reset(reset), .go(go3), .pu_done(pu_done3), .final_score(final_score3),
    .pu_reset(pu_reset3), .pu_start(pu_start3), .bound_top(bound_top3),
    .bound_left(bound_left3), .busy(busy3), .done(done3), .score(score3)
  );

  nw_wavefront_ctrl #(.N(1), .M(1), .GAP(-32'sd1)) dut1 (
    .clk(clk), .reset(reset), .go(go1), .pu_done(pu_done1), .final_score(final_score1),
    .pu_reset(pu_reset1), .pu_start(pu_start1), .bound_top(bound_top1),
    .bound_left(bound_left1), .busy(busy1), .done(done1), .score(score1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign pu_done3     = done_m & ~hold_mask;
  assign final_score3 = use_model ? 32'(h_m[8]) : fixed_score;
  assign final_score1 = 32'sd9;

  function automatic int bt(input int j);
    return $signed(bound_top3[j*32 +: 32]);
  endfunction

  function automatic int bl(input int i);
    return $signed(bound_left3[i*32 +: 32]);
  endfunction

  // NW recurrence for cell (i,j) = H[i+1][j+1]; match +1, mismatch -1, gap -1.
  function automatic int cell_val(input int i, input int j);
    int dg, up, lf, best;
    dg = (i == 0) ? bt(j) : ((j == 0) ? bl(i) : h_m[(i-1)*3 + (j-1)]);
    up = (i == 0) ? bt(j+1) : h_m[(i-1)*3 + j];
    lf = (j == 0) ? bl(i+1) : h_m[i*3 + (j-1)];
    best = dg + ((seq_a[i] == seq_b[j]) ? 1 : -1);
    if (up - 1 > best) best = up - 1;
    if (lf - 1 > best) best = lf - 1;
    return best;
  endfunction

  // 3x3 cell array model: registers its score and done on the edge after start.
  always @(posedge clk) begin
    if (pu_reset3) begin
      done_m <= '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        for (int j = 0; j < 3; j++) begin
          if (pu_start3[i*3+j] && !done_m[i*3+j]) begin
            h_m[i*3+j]    <= cell_val(i, j);
            done_m[i*3+j] <= 1'b1;
          end
        end
      end
    end
  end

  // 1x1 cell model.
  always @(posedge clk) begin
    if (pu_reset1) pu_done1 <= 1'b0;
    else if (pu_start1[0]) pu_done1 <= 1'b1;
  end

  // Pulse go for one cycle on the 3x3 instance; report cycles to done and WAVE cycles.
  task automatic run_go(output int lat, output int wave);
    lat  = -1;
    wave = 0;
    go3  = 1'b1;
    for (int c = 1; c <= 80; c++) begin
      @(negedge clk);
      go3 = 1'b0;
      if (pu_start3 != 9'd0) wave++;
      if (done3) begin
        lat = c;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++; if (busy3 !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy3); else n_pass++;
    n_checks++; if (done3 !== 1'b0) $display("FAIL reset_done: got %b want 0", done3); else n_pass++;
    n_checks++; if (score3 !== 32'sd0) $display("FAIL reset_score: got %0d want 0", score3); else n_pass++;
    n_checks++; if (pu_start3 !== 9'd0) $display("FAIL reset_start: got %b want 0", pu_start3); else n_pass++;
    n_checks++; if (pu_reset3 !== 1'b1) $display("FAIL reset_pu_reset: got %b want 1", pu_reset3); else n_pass++;
    n_checks++; if ((bound_top3 | bound_left3) !== 128'd0) $display("FAIL reset_bounds: got %h want 0", bound_top3 | bound_left3); else n_pass++;
    reset = 1'b1;
    @(negedge clk);
    n_checks++; if (pu_reset3 !== 1'b0) $display("FAIL idle_pu_reset: got %b want 0", pu_reset3); else n_pass++;
  endtask

  task automatic test_basic();
    logic [127:0] exp_b;
    int lat, wave;
    exp_b = {-32'sd3, -32'sd2, -32'sd1, 32'sd0};
    use_model = 1'b0;
    fixed_score = 32'sd2;
    @(negedge clk);
    lat = -1; wave = 0;
    go3 = 1'b1;
    for (int c = 1; c <= 80; c++) begin
      @(negedge clk);
      go3 = 1'b0;
      if (c == 1) begin
        n_checks++; if (busy3 !== 1'b1) $display("FAIL basic_busy: got %b want 1", busy3); else n_pass++;
        n_checks++; if (pu_reset3 !== 1'b1) $display("FAIL basic_clear: got %b want 1", pu_reset3); else n_pass++;
      end
      if (c == 6) begin
        n_checks++; if (bound_top3 !== exp_b) $display("FAIL basic_bound_top: got %h want %h", bound_top3, exp_b); else n_pass++;
        n_checks++; if (bound_left3 !== exp_b) $display("FAIL basic_bound_left: got %h want %h", bound_left3, exp_b); else n_pass++;
        n_checks++; if (pu_start3 !== 9'b000000001) $display("FAIL basic_first_diag: got %b want 000000001", pu_start3); else n_pass++;
      end
      if (pu_start3 != 9'd0) wave++;
      if (done3) begin
        lat = c;
        break;
      end
    end
    n_checks++; if (lat !== 16) $display("FAIL basic_latency: got %0d want 16", lat); else n_pass++;
    n_checks++; if (wave !== 10) $display("FAIL basic_wave_cycles: got %0d want 10", wave); else n_pass++;
    n_checks++; if (score3 !== 32'sd2) $display("FAIL basic_score: got %0d want 2", score3); else n_pass++;
    @(negedge clk);
    n_checks++; if ({busy3, done3, pu_start3} !== 11'd0) $display("FAIL basic_idle: got %b want 0", {busy3, done3, pu_start3}); else n_pass++;
    n_checks++; if (score3 !== 32'sd2) $display("FAIL basic_score_hold: got %0d want 2", score3); else n_pass++;
  endtask

  task automatic test_scoreboard();
    int lat, wave;
    use_model = 1'b1;
    @(negedge clk);
    run_go(lat, wave);
    n_checks++; if (lat !== 16) $display("FAIL sb_latency: got %0d want 16", lat); else n_pass++;
    n_checks++; if (score3 !== 32'sd1) $display("FAIL sb_score: got %0d want 1", score3); else n_pass++;
  endtask

  task automatic test_single();
    int lat, starts;
    @(negedge clk);
    lat = -1; starts = 0;
    go1 = 1'b1;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      go1 = 1'b0;
      if (pu_start1 == 1'b1) starts++;
      if (done1) begin
        lat = c;
        break;
      end
    end
    n_checks++; if (lat !== 6) $display("FAIL single_latency: got %0d want 6", lat); else n_pass++;
    n_checks++; if (starts !== 2) $display("FAIL single_start_cycles: got %0d want 2", starts); else n_pass++;
    n_checks++; if (score1 !== 32'sd9) $display("FAIL single_score: got %0d want 9", score1); else n_pass++;
    n_checks++; if (bound_top1 !== {-32'sd1, 32'sd0}) $display("FAIL single_bound: got %h want ffffffff00000000", bound_top1); else n_pass++;
  endtask

  task automatic test_go_held();
    int lat, lat2;
    use_model = 1'b0;
    fixed_score = 32'sd7;
    @(negedge clk);
    lat = -1; lat2 = -1;
    go3 = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (done3) begin
        lat = c;
        break;
      end
    end
    n_checks++; if (lat !== 16) $display("FAIL held_latency: got %0d want 16", lat); else n_pass++;
    n_checks++; if (score3 !== 32'sd7) $display("FAIL held_score: got %0d want 7", score3); else n_pass++;
    @(negedge clk);
    n_checks++; if (busy3 !== 1'b0) $display("FAIL held_idle_gap: got %b want 0", busy3); else n_pass++;
    fixed_score = -32'sd5;
    @(negedge clk);
    n_checks++; if ({busy3, pu_reset3} !== 2'b11) $display("FAIL held_retrigger: got %b want 11", {busy3, pu_reset3}); else n_pass++;
    n_checks++; if (score3 !== 32'sd7) $display("FAIL held_score_clear: got %0d want 7", score3); else n_pass++;
    go3 = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++; if (score3 !== 32'sd7) $display("FAIL held_score_init: got %0d want 7", score3); else n_pass++;
    for (int c = 21; c <= 60; c++) begin
      @(negedge clk);
      if (done3) begin
        lat2 = c;
        break;
      end
    end
    n_checks++; if (lat2 !== 33) $display("FAIL held_second_latency: got %0d want 33", lat2); else n_pass++;
    n_checks++; if (score3 !== -32'sd5) $display("FAIL held_second_score: got %0d want -5", score3); else n_pass++;
  endtask

  task automatic test_reset_mid_wave();
    int lat, wave;
    use_model = 1'b1;
    @(negedge clk);
    go3 = 1'b1;
    @(negedge clk);
    go3 = 1'b0;
    repeat (7) @(negedge clk);
    reset = 1'b0;
    #1;
    n_checks++; if ({busy3, done3} !== 2'b00) $display("FAIL midrst_busy_done: got %b want 00", {busy3, done3}); else n_pass++;
    n_checks++; if (pu_start3 !== 9'd0) $display("FAIL midrst_start: got %b want 0", pu_start3); else n_pass++;
    n_checks++; if (pu_reset3 !== 1'b1) $display("FAIL midrst_pu_reset: got %b want 1", pu_reset3); else n_pass++;
    n_checks++; if ((bound_top3 | bound_left3) !== 128'd0) $display("FAIL midrst_bounds: got %h want 0", bound_top3 | bound_left3); else n_pass++;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    run_go(lat, wave);
    n_checks++; if (lat !== 16) $display("FAIL midrst_rerun_latency: got %0d want 16", lat); else n_pass++;
    n_checks++; if (score3 !== 32'sd1) $display("FAIL midrst_rerun_score: got %0d want 1", score3); else n_pass++;
  endtask

  task automatic test_stall();
    int lat, held;
    logic early;
    use_model = 1'b1;
    @(negedge clk);
    lat = -1; held = 0; early = 1'b0;
    hold_mask = 9'b000010000;
    go3 = 1'b1;
    for (int c = 1; c <= 80; c++) begin
      @(negedge clk);
      go3 = 1'b0;
      if (pu_start3[2] && (hold_mask != 9'd0)) begin
        held++;
        if (held == 6) begin
          n_checks++; if (pu_start3[5] !== 1'b0) $display("FAIL stall_d_advanced: got %b want 0", pu_start3[5]); else n_pass++;
          hold_mask = 9'd0;
        end
      end
      if (done3) begin
        lat = c;
        break;
      end
      if (c < 20 && done3) early = 1'b1;
    end
    hold_mask = 9'd0;
    n_checks++; if (held !== 6) $display("FAIL stall_held_cycles: got %0d want 6", held); else n_pass++;
    n_checks++; if (lat !== 20) $display("FAIL stall_latency: got %0d want 20", lat); else n_pass++;
    n_checks++; if (score3 !== 32'sd1) $display("FAIL stall_score: got %0d want 1", score3); else n_pass++;
    @(negedge clk);
  endtask

  initial begin
    seq_a = '{8'h47, 8'h41, 8'h54};
    seq_b = '{8'h47, 8'h43, 8'h54};
    reset = 1'b0;
    go3 = 1'b0;
    go1 = 1'b0;
    hold_mask = 9'd0;
    use_model = 1'b0;
    fixed_score = 32'sd0;
    test_reset();
    test_basic();
    test_scoreboard();
    test_single();
    test_go_held();
    test_reset_mid_wave();
    test_stall();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
